// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED bank sequencer: prescaled step ticks, four patterns, pause/single-step
// Optional: define SEQ_AUTOCYCLE_EN to rotate through all modes automatically.
module led_seq_ctrl #(
  parameter int TICK_DIV = 6000000,
  parameter int LED_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_sel,
  input  logic [1:0]       speed_sel,
  input  logic             pause,
  input  logic             step,
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic [1:0]       mode_q
);

  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CYW = $clog2(2 * LED_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    lim;
  logic             adv;
  logic             dir, dir_nxt;
  logic             reload;
  logic [1:0]       tgt;
  logic [1:0]       mode_nxt;
  logic [LED_W-1:0] led_nxt;
`ifdef SEQ_AUTOCYCLE_EN
  logic [CYW-1:0]   cyc, cyc_nxt;
`endif

  function automatic logic [LED_W-1:0] init_pat(input logic [1:0] m);
    case (m)
      2'd1:    init_pat = ~(LED_W'(1) << (LED_W - 1));
      2'd3:    init_pat = '0;
      default: init_pat = ~LED_W'(1);
    endcase
  endfunction

  function automatic logic legal(input logic [1:0] m, input logic [LED_W-1:0] v);
    if (m == 2'd3)
      legal = (v == '0) || (v == '1);
    else
      legal = $onehot(~v);
  endfunction

  function automatic logic [CYW-1:0] cyc_len(input logic [1:0] m);
    case (m)
      2'd2:    cyc_len = CYW'(2 * LED_W - 2);
      2'd3:    cyc_len = CYW'(2);
      default: cyc_len = CYW'(LED_W);
    endcase
  endfunction

  // A shrinking period can leave cnt above the new limit; >= wraps it on the next cycle.
  assign lim = CW'((TICK_DIV >> speed_sel) - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= lim) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

  assign adv = (tick & ~pause) | (step & pause);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      led    <= '1;
      mode_q <= 2'd0;
      dir    <= 1'b0;
`ifdef SEQ_AUTOCYCLE_EN
      cyc    <= '0;
`endif
    end else begin
      state  <= state_nxt;
      led    <= led_nxt;
      mode_q <= mode_nxt;
      dir    <= dir_nxt;
`ifdef SEQ_AUTOCYCLE_EN
      cyc    <= cyc_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    if (adv)
      state_nxt = RUN;
  end

  // dir: 0 = shifting toward MSB (left), 1 = toward LSB (right); only bounce uses it.
  always_comb begin
    led_nxt  = led;
    mode_nxt = mode_q;
    dir_nxt  = dir;
    reload   = 1'b0;
    tgt      = mode_q;
`ifdef SEQ_AUTOCYCLE_EN
    cyc_nxt  = cyc;
`endif
    if (adv) begin
`ifdef SEQ_AUTOCYCLE_EN
      if (state == IDLE) begin
        reload = 1'b1;
      end else if (cyc == cyc_len(mode_q) - CYW'(1)) begin
        tgt    = mode_q + 2'd1;
        reload = 1'b1;
      end else if (!legal(mode_q, led)) begin
        reload = 1'b1;
      end
`else
      tgt = mode_sel;
      if (state == IDLE || mode_sel != mode_q || !legal(mode_q, led))
        reload = 1'b1;
`endif
      if (reload) begin
        mode_nxt = tgt;
        led_nxt  = init_pat(tgt);
        dir_nxt  = 1'b0;
`ifdef SEQ_AUTOCYCLE_EN
        cyc_nxt  = '0;
`endif
      end else begin
`ifdef SEQ_AUTOCYCLE_EN
        cyc_nxt = cyc + CYW'(1);
`endif
        case (mode_q)
          2'd0: led_nxt = {led[LED_W-2:0], led[LED_W-1]};
          2'd1: led_nxt = {led[0], led[LED_W-1:1]};
          2'd2: begin
            if (led == init_pat(2'd1)) begin
              dir_nxt = 1'b1;
              led_nxt = {led[0], led[LED_W-1:1]};
            end else if (led == init_pat(2'd0)) begin
              dir_nxt = 1'b0;
              led_nxt = {led[LED_W-2:0], led[LED_W-1]};
            end else if (dir) begin
              led_nxt = {led[0], led[LED_W-1:1]};
            end else begin
              led_nxt = {led[LED_W-2:0], led[LED_W-1]};
            end
          end
          default: led_nxt = ~led;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - scoreboard bench for led_seq_ctrl against a phase-index reference model
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode_sel, speed_sel;
  logic       pause, step;
  logic [7:0] led;
  logic       tick;
  logic [1:0] mode_q;

  led_seq_ctrl #(.TICK_DIV(8), .LED_W(8)) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .speed_sel(speed_sel),
    .pause(pause), .step(step), .led(led), .tick(tick), .mode_q(mode_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] led;
    logic       tick;
    logic [1:0] mode;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int m_cnt, m_mode, m_phase, m_lim;
  bit m_tick, m_idle, m_adv;

  function automatic int plen(input int m);
    if (m < 2) return 8;
    if (m == 2) return 14;
    return 2;
  endfunction

  // Position of the dark-is-lit LED from the pattern phase, not from the previous output.
  function automatic logic [7:0] pat(input int m, input int ph);
    logic [7:0] one;
    logic [7:0] top;
    one = 8'h01;
    top = 8'h80;
    case (m)
      0: return ~(one << ph);
      1: return ~(top >> ph);
      2: return (ph <= 7) ? ~(one << ph) : ~(one << (14 - ph));
      default: return (ph == 0) ? 8'h00 : 8'hFF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_cnt = 0; m_tick = 0; m_idle = 1; m_mode = 0; m_phase = 0;
    end else begin
      m_adv = (m_tick && !pause) || (step && pause);
      m_lim = (8 >> speed_sel) - 1;
      if (m_cnt >= m_lim) begin
        m_cnt = 0; m_tick = 1;
      end else begin
        m_cnt = m_cnt + 1; m_tick = 0;
      end
      if (m_adv) begin
`ifdef SEQ_AUTOCYCLE_EN
        if (m_idle) begin
          m_idle = 0; m_phase = 0;
        end else if (m_phase == plen(m_mode) - 1) begin
          m_mode = (m_mode + 1) % 4; m_phase = 0;
        end else begin
          m_phase = m_phase + 1;
        end
`else
        if (m_idle) begin
          m_idle = 0; m_mode = int'(mode_sel); m_phase = 0;
        end else if (int'(mode_sel) != m_mode) begin
          m_mode = int'(mode_sel); m_phase = 0;
        end else begin
          m_phase = (m_phase + 1) % plen(m_mode);
        end
`endif
      end
    end
    sbq.push_back('{m_idle ? 8'hFF : pat(m_mode, m_phase), m_tick, 2'(m_mode)});
  end

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_chk++;
      if (led !== e.led) begin
        n_fail++;
        $display("FAIL led t=%0t got=%h exp=%h", $time, led, e.led);
      end
      n_chk++;
      if (tick !== e.tick) begin
        n_fail++;
        $display("FAIL tick t=%0t got=%b exp=%b", $time, tick, e.tick);
      end
      n_chk++;
      if (mode_q !== e.mode) begin
        n_fail++;
        $display("FAIL mode_q t=%0t got=%0d exp=%0d", $time, mode_q, e.mode);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b0; mode_sel = 2'd0; speed_sel = 2'd0; pause = 1'b0; step = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(100);

    mode_sel = 2'd2;
    cycles(240);

    // Switch to the fastest speed while the model's count is mid-period.
    k = 0;
    while (m_cnt != 5 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (m_cnt != 5) begin
      n_fail++;
      $display("FAIL cnt_wait got=%0d exp=5", m_cnt);
    end
    speed_sel = 2'd3;
    cycles(20);
    speed_sel = 2'd2;
    cycles(20);
    speed_sel = 2'd0;

    pause = 1'b1;
    cycles(30);
    pulse_step();
    cycles(5);
    pulse_step();
    mode_sel = 2'd3;
    cycles(20);
    pulse_step();
    cycles(3);
    pause = 1'b0;
    cycles(3);
    pulse_step();
    cycles(30);

    mode_sel = 2'd0;
    cycles(40);
    mode_sel = 2'd1;
    cycles(20);

    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (led !== 8'hFF || tick !== 1'b0 || mode_q !== 2'd0) begin
      n_fail++;
      $display("FAIL async_rst got led=%h tick=%b mode=%0d exp led=ff tick=0 mode=0", led, tick, mode_q);
    end
    cycles(2);
    #2 rst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 2) mode_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2) speed_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) pause = ~pause;
      step = ($urandom_range(0, 99) < 5);
    end
    step = 1'b0;
    cycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
